// File: rtl/systolic_result_drain.sv
// rtl/systolic_result_drain.sv - snapshots the systolic array C bus after a fixed delay and streams it out
module systolic_result_drain #(
    parameter int N           = 3,
    parameter int ACC_W       = 16,
    parameter int DRAIN_DELAY = 8,
    localparam int NE         = N * N,
    localparam int IDX_W      = (NE > 1) ? $clog2(NE) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NE*ACC_W-1:0]   c_flat,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [ACC_W-1:0]      out_data,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = (DRAIN_DELAY > 1) ? $clog2(DRAIN_DELAY) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DRAIN_DELAY - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STREAM
    } state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [NE-1:0][ACC_W-1:0]     snap_q, snap_d;
    logic                         done_q, done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                // The array has settled by now; later c_flat changes must not leak into the stream.
                if (cnt_q == LAST_CNT) begin
                    snap_d  = c_flat;
                    idx_d   = '0;
                    state_d = S_STREAM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are forced to zero outside STREAM so an idle port shows no stale element.
    assign out_valid = (state_q == S_STREAM);
    assign out_data  = out_valid ? snap_q[idx_q] : '0;
    assign out_idx   = out_valid ? idx_q : '0;
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb/tb_systolic_result_drain.sv - scoreboard bench for systolic_result_drain
module tb_systolic_result_drain;

    localparam int N     = 3;
    localparam int ACC_W = 16;
    localparam int D     = 8;
    localparam int NE    = N * N;
    localparam int IW    = $clog2(NE);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 out_ready = 1'b0;
    logic [NE*ACC_W-1:0]  c_flat = '0;
    logic                 out_valid;
    logic [ACC_W-1:0]     out_data;
    logic [IW-1:0]        out_idx;
    logic                 out_last;
    logic                 busy;
    logic                 done;

    systolic_result_drain #(.N(N), .ACC_W(ACC_W), .DRAIN_DELAY(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .c_flat    (c_flat),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ACC_W-1:0] d;
        logic [IW-1:0]    i;
        logic             l;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int n_xfer = 0;
    int n_done = 0;
    logic             prev_valid = 1'b0;
    logic             prev_rdy   = 1'b0;
    logic [ACC_W-1:0] prev_data  = '0;
    logic [IW-1:0]    prev_idx   = '0;

    logic [ACC_W-1:0] job_a [NE] = '{16'd30, 16'd36, 16'd42, 16'd66, 16'd81, 16'd96, 16'd102, 16'd126, 16'd150};
    logic [ACC_W-1:0] job_b [NE] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [ACC_W-1:0] v [NE]);
        exp_t e;
        for (int i = 0; i < NE; i++) begin
            c_flat[i*ACC_W +: ACC_W] = v[i];
            e.d = v[i];
            e.i = IW'(i);
            e.l = (i == NE - 1);
            sb.push_back(e);
        end
    endtask

    // Drives inputs for the coming edge, scores any transfer it will cause, then samples 1ns after the edge.
    task automatic step(input logic rdy, input logic st);
        exp_t e;
        out_ready = rdy;
        start     = st;
        if (prev_valid && !prev_rdy) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(prev_data));
            chk("stall_idx", 32'(out_idx), 32'(prev_idx));
        end
        if (out_valid && rdy) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL extra_xfer observed=idx%0d expected=no transfer", out_idx);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("xfer_data", 32'(out_data), 32'(e.d));
                chk("xfer_idx", 32'(out_idx), 32'(e.i));
                chk("xfer_last", 32'(out_last), 32'(e.l));
            end
            n_xfer++;
        end
        prev_valid = out_valid;
        prev_rdy   = rdy;
        prev_data  = out_data;
        prev_idx   = out_idx;
        @(posedge clk);
        #1;
        if (done) begin
            n_done++;
            chk("busy_with_done", 32'(busy), 32'd0);
        end
    endtask

    task automatic wait_valid(input logic rdy);
        int t = 0;
        while (!out_valid && t < 50) begin
            step(rdy, 1'b0);
            t++;
        end
        chk("wait_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic drain(input int max_steps);
        int t = 0;
        while (sb.size() > 0 && t < max_steps) begin
            step(1'b1, 1'b0);
            t++;
        end
        chk("drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int x0;

        // Reset state
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic drain with exact latency and full throughput
        n_done = 0;
        load(job_a);
        step(1'b1, 1'b1);
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int k = 1; k <= D; k++) begin
            step(1'b1, 1'b0);
            chk("valid_rise_basic", 32'(out_valid), 32'(k == D));
        end
        for (int k = 0; k < NE; k++) step(1'b1, 1'b0);
        chk("basic_sb_empty", 32'(sb.size()), 32'd0);
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_busy_low", 32'(busy), 32'd0);
        chk("basic_valid_low", 32'(out_valid), 32'd0);
        step(1'b1, 1'b0);
        chk("basic_done_one_cycle", 32'(done), 32'd0);
        chk("basic_done_count", 32'(n_done), 32'd1);

        // Backpressure: stall on idx 2, then toggle ready
        n_done = 0;
        x0 = n_xfer;
        load(job_a);
        step(1'b1, 1'b1);
        wait_valid(1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("bp_idx_at_stall", 32'(out_idx), 32'd2);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        for (int t = 0; t < 40 && sb.size() > 0; t++) step(logic'(t % 2 == 0), 1'b0);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);
        chk("bp_xfers", 32'(n_xfer - x0), 32'd9);
        chk("bp_done_count", 32'(n_done), 32'd1);

        // Snapshot isolation
        n_done = 0;
        load(job_a);
        step(1'b1, 1'b1);
        wait_valid(1'b1);
        step(1'b1, 1'b0);
        c_flat = '1;
        drain(20);
        chk("snap_done_count", 32'(n_done), 32'd1);

        // Start ignored while busy
        n_done = 0;
        x0 = n_xfer;
        load(job_a);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        wait_valid(1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        drain(20);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0);
        chk("ign_no_second_job", 32'(out_valid | busy), 32'd0);
        chk("ign_xfers", 32'(n_xfer - x0), 32'd9);
        chk("ign_done_count", 32'(n_done), 32'd1);

        // Asynchronous reset mid-stream
        load(job_a);
        step(1'b1, 1'b1);
        wait_valid(1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_idx", 32'(out_idx), 32'd0);
        chk("arst_last", 32'(out_last), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        sb.delete();
        prev_valid = 1'b0;
        n_done = 0;
        @(posedge clk);
        #1;
        chk("arst_no_done", 32'(done), 32'd0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        load(job_a);
        step(1'b1, 1'b1);
        wait_valid(1'b1);
        chk("arst_restart_idx", 32'(out_idx), 32'd0);
        drain(20);
        chk("arst_done_count", 32'(n_done), 32'd1);

        // Back-to-back jobs: start accepted in the done cycle
        n_done = 0;
        load(job_a);
        step(1'b1, 1'b1);
        wait_valid(1'b1);
        drain(20);
        chk("b2b_done_first", 32'(done), 32'd1);
        load(job_b);
        step(1'b1, 1'b1);
        for (int k = 1; k <= D; k++) begin
            step(1'b1, 1'b0);
            chk("b2b_gap", 32'(out_valid), 32'(k == D));
        end
        drain(20);
        step(1'b1, 1'b0);
        chk("b2b_done_count", 32'(n_done), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
